fm0_tx_encoder: RTL and testbench
=================================

# fm0_tx_encoder

Backscatter transmit stage that sits directly downstream of the byte FIFO in the tag datapath. On a start pulse it emits a fixed FM0 preamble, pops a given number of bytes from the FIFO, and FM0-encodes them MSB-first onto a single modulator output. It then appends the end-of-signalling dummy '1'. It owns the FIFO read strobe and reports completion or underrun to the tag control FSM.

## Interface
- HALF_CYCLES, 4: clk cycles per FM0 half-symbol (≥2).
- PREAMBLE, 12'b1101_0010_0011: preamble half-symbol levels, sent MSB first.
- clk  in  1  system clock; the only clock in this block.
- reset_n  in  1  reset, synchronous, active-low.
- en  in  1  global enable; 0 freezes all state while asserted.
- start  in  1  one-cycle request to begin a frame.
- byte_count  in  8  bytes to send; sampled on the accepted start.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  8  FIFO read data; valid the cycle after fifo_read.
- fifo_read  out  1  one-cycle pop strobe to the FIFO.
- tx_out  out  1  FM0 modulator level.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse at normal frame end.
- underrun  out  1  sticky; FIFO was empty at a fetch.

## Operation
- States: IDLE, PREAMBLE, DATA, DUMMY, DONE.
- Reset (reset_n=0 at a clk edge):
  - state=IDLE; fifo_read, tx_out, busy, done and underrun all 0.
  - Applies even in mid-frame, with no partial output.
- IDLE:
  - start=1 && en=1 && byte_count≠0 → PREAMBLE.
    - Latches byte_count.
    - Clears underrun.
    - Sets busy=1.
  - start with byte_count=0 → done pulse next cycle, no transmission.
  - start while busy is ignored.
- PREAMBLE:
  - 12 half-symbols of PREAMBLE, each held HALF_CYCLES cycles.
  - Prefetch of the first byte:
    - On the first PREAMBLE cycle, if fifo_empty=0, pulse fifo_read.
    - Latch fifo_data into the shift register on the next cycle.
- DATA:
  - 8 bits per byte, MSB first. One symbol = 2 half-symbols.
  - FM0 rule: each symbol starts at the inverse of the previous half-symbol level.
    - Bit 1: level held for the whole symbol.
    - Bit 0: level inverts at mid-symbol.
  - The previous level for the first data bit is the last preamble half-symbol (1).
  - Prefetch of following bytes:
    - On the first cycle of bit 0 (LSB) of a byte, if bytes remain and fifo_empty=0, pulse fifo_read.
    - The new byte loads at the symbol boundary with no gap.
  - Remaining byte counter decrements on each byte load.
- Fetch with fifo_empty=1:
  - Set underrun=1.
  - Abort at the current half-symbol boundary: tx_out=0, busy=0, → IDLE.
  - No done pulse.
- DUMMY: one FM0 '1' symbol after the last byte.
- DONE: tx_out=0, busy=0, done=1 for one cycle, → IDLE.
- en=0 while busy: half-symbol counter, state and tx_out hold; fifo_read is forced 0. Operation resumes exactly where it stopped.

## Timing
- Latency:
  - The start edge is cycle 0.
  - First tx_out preamble level appears at cycle 1.
  - busy rises at cycle 1.
- Frame length, with N = byte_count: (12 + 16·N + 2)·HALF_CYCLES cycles with busy=1, followed by the done cycle.
- Level changes of tx_out occur only on half-symbol boundaries and are registered (glitch-free).
- fifo_read:
  - Never asserted for two consecutive cycles.
  - Asserted at most byte_count times per frame.
  - Never asserted while fifo_empty=1.
- Counter widths:
  - Half-symbol counter: $clog2(HALF_CYCLES).
  - Bit counter: 3 bits.
  - Byte counter: 8 bits.
  - No wrap within a frame.
- underrun holds until the next accepted start or reset.

## Test plan
- Reset mid-frame:
  - Stimulus: reset_n=0 for 1 cycle during DATA.
  - Required: next cycle tx_out=0, busy=0, fifo_read=0, underrun=0; the next start runs a complete frame.
- Single byte, HALF_CYCLES=2:
  - Stimulus: FIFO holds 0xA5, byte_count=1, start.
  - Required: tx_out half-symbols are 110100100011, then 00 10 11 01 01 00 10 11, then dummy 00.
  - Required: busy high for 60 cycles, one fifo_read, done pulses once.
- Back-to-back bytes:
  - Stimulus: FIFO holds 0x00 and 0xFF, byte_count=2.
  - Required: no gap at the byte boundary; 0x00 produces an inversion every half-symbol.
  - Required: 0xFF produces a transition only at symbol boundaries; exactly 2 fifo_read pulses.
- Underrun:
  - Stimulus: FIFO holds 1 byte, byte_count=3.
  - Required: underrun=1 after byte 1; tx_out=0; busy=0; no done; fifo_read pulsed once.
- Enable stall:
  - Stimulus: en=0 for 7 cycles mid-symbol.
  - Required: tx_out is frozen for the stall; the waveform is otherwise identical to the unstalled run, shifted by 7 cycles.
- Zero-length and ignored start:
  - Stimulus: start with byte_count=0.
  - Required: done pulses at cycle 1 and tx_out stays 0.
  - Stimulus: start during busy.
  - Required: no effect on the frame.

Source files
------------

// File: rtl/fm0_tx_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : fm0_tx_encoder
//  Description : Backscatter transmit stage. On an accepted start it sends a
//                fixed FM0 preamble, pops byte_count bytes from the upstream
//                byte FIFO, FM0-encodes them MSB first onto a single
//                modulator level and appends the end-of-signalling dummy '1'
//                symbol. It owns the FIFO pop strobe and reports normal
//                completion (done) or an empty FIFO at a fetch (underrun).
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    HALF_CYCLES   clk cycles per FM0 half-symbol (must be >= 2)
//    PREAMBLE      preamble half-symbol levels, sent MSB first
//  Ports
//    i_clk         system clock
//    i_reset_n     synchronous active-low reset
//    i_en          global enable; 0 freezes the frame in place
//    i_start       one-cycle frame request (accepted only when idle)
//    i_byte_count  bytes to send, sampled on the accepted start
//    i_fifo_empty  FIFO empty flag
//    i_fifo_data   FIFO read data, valid the cycle after o_fifo_read
//    o_fifo_read   one-cycle FIFO pop strobe
//    o_tx_out      FM0 modulator level (registered)
//    o_busy        frame in progress
//    o_done        one-cycle pulse at normal frame end
//    o_underrun    sticky; FIFO was empty at a fetch
// ============================================================================
module fm0_tx_encoder #(
    parameter int          HALF_CYCLES = 4,
    parameter logic [11:0] PREAMBLE    = 12'b1101_0010_0011
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_en,
    input  logic       i_start,
    input  logic [7:0] i_byte_count,
    input  logic       i_fifo_empty,
    input  logic [7:0] i_fifo_data,
    output logic       o_fifo_read,
    output logic       o_tx_out,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_underrun
);

    localparam int             c_HCW     = (HALF_CYCLES > 1) ? $clog2(HALF_CYCLES) : 1;
    localparam logic [c_HCW-1:0] c_HC_LAST = c_HCW'(HALF_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREAMBLE = 3'd1,
        S_DATA     = 3'd2,
        S_DUMMY    = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t           r_state;
    logic [c_HCW-1:0] r_hcnt;        // cycle within the current half-symbol
    logic [3:0]       r_pidx;        // preamble half-symbol index, 0..11
    logic [2:0]       r_bit;         // data bit index, 7 (MSB) down to 0
    logic             r_half;        // 0: first half of symbol, 1: second half
    logic [7:0]       r_shift;       // byte currently being transmitted
    logic [7:0]       r_next;        // prefetched next byte
    logic [7:0]       r_bytes_left;  // bytes not yet loaded into r_shift
    logic             r_abort;       // underrun seen, stop at next boundary
    logic             r_fifo_read;
    logic             r_rd_d;        // a pop happened last cycle
    logic             r_tx;
    logic             r_busy;
    logic             r_done;
    logic             r_underrun;

    logic             w_hs_end;
    logic             w_pop;

    assign w_hs_end = (r_hcnt == c_HC_LAST);

    // The strobe is held in r_fifo_read across a stall and only reaches the
    // FIFO once enable returns, so no pop is lost or duplicated.
    assign w_pop = r_fifo_read & i_en;

    assign o_fifo_read = w_pop;
    assign o_tx_out    = r_tx;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_underrun  = r_underrun;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state      <= S_IDLE;
            r_hcnt       <= '0;
            r_pidx       <= 4'd0;
            r_bit        <= 3'd0;
            r_half       <= 1'b0;
            r_shift      <= 8'd0;
            r_next       <= 8'd0;
            r_bytes_left <= 8'd0;
            r_abort      <= 1'b0;
            r_fifo_read  <= 1'b0;
            r_rd_d       <= 1'b0;
            r_tx         <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            // FIFO data is valid exactly one cycle after a real pop. The first
            // byte goes straight into the shift register (it is idle during
            // the preamble); later bytes wait in r_next for the symbol edge.
            r_rd_d <= w_pop;
            if (r_rd_d) begin
                if (r_state == S_PREAMBLE) begin
                    r_shift <= i_fifo_data;
                end else begin
                    r_next <= i_fifo_data;
                end
            end

            if (i_en) begin
                r_fifo_read <= 1'b0;
                r_done      <= 1'b0;

                case (r_state)
                    S_IDLE: begin
                        if (i_start) begin
                            if (i_byte_count == 8'd0) begin
                                // Empty frame: report completion only.
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state      <= S_PREAMBLE;
                                r_busy       <= 1'b1;
                                r_tx         <= PREAMBLE[11];
                                r_pidx       <= 4'd0;
                                r_hcnt       <= '0;
                                r_bytes_left <= i_byte_count;
                                r_underrun   <= 1'b0;
                                r_abort      <= 1'b0;
                                // Prefetch of the first byte lands on the
                                // first preamble cycle.
                                if (i_fifo_empty) begin
                                    r_underrun <= 1'b1;
                                    r_abort    <= 1'b1;
                                end else begin
                                    r_fifo_read <= 1'b1;
                                end
                            end
                        end
                    end

                    S_DONE: begin
                        r_state <= S_IDLE;
                    end

                    S_PREAMBLE, S_DATA, S_DUMMY: begin
                        if (!w_hs_end) begin
                            r_hcnt <= r_hcnt + 1'b1;
                        end else begin
                            r_hcnt <= '0;
                            if (r_abort) begin
                                // Underrun: drop the carrier at this boundary.
                                r_state <= S_IDLE;
                                r_tx    <= 1'b0;
                                r_busy  <= 1'b0;
                                r_abort <= 1'b0;
                            end else if (r_state == S_PREAMBLE) begin
                                if (r_pidx != 4'd11) begin
                                    r_pidx <= r_pidx + 4'd1;
                                    r_tx   <= PREAMBLE[4'd10 - r_pidx];
                                end else begin
                                    // First data symbol starts inverted from
                                    // the last preamble half-symbol.
                                    r_state      <= S_DATA;
                                    r_bit        <= 3'd7;
                                    r_half       <= 1'b0;
                                    r_tx         <= ~r_tx;
                                    r_bytes_left <= r_bytes_left - 8'd1;
                                end
                            end else if (r_state == S_DATA) begin
                                if (!r_half) begin
                                    // Mid-symbol: a '0' inverts, a '1' holds.
                                    r_half <= 1'b1;
                                    if (!r_shift[r_bit]) begin
                                        r_tx <= ~r_tx;
                                    end
                                end else begin
                                    // Symbol boundary always inverts.
                                    r_half <= 1'b0;
                                    r_tx   <= ~r_tx;
                                    if (r_bit != 3'd0) begin
                                        r_bit <= r_bit - 3'd1;
                                        // Entering the LSB: fetch the next
                                        // byte so it is ready at the end of
                                        // this symbol.
                                        if ((r_bit == 3'd1) && (r_bytes_left != 8'd0)) begin
                                            if (i_fifo_empty) begin
                                                r_underrun <= 1'b1;
                                                r_abort    <= 1'b1;
                                            end else begin
                                                r_fifo_read <= 1'b1;
                                            end
                                        end
                                    end else if (r_bytes_left != 8'd0) begin
                                        r_shift      <= r_next;
                                        r_bytes_left <= r_bytes_left - 8'd1;
                                        r_bit        <= 3'd7;
                                    end else begin
                                        r_state <= S_DUMMY;
                                    end
                                end
                            end else begin
                                // Dummy '1': level held for both halves.
                                if (!r_half) begin
                                    r_half <= 1'b1;
                                end else begin
                                    r_half  <= 1'b0;
                                    r_state <= S_DONE;
                                    r_tx    <= 1'b0;
                                    r_busy  <= 1'b0;
                                    r_done  <= 1'b1;
                                end
                            end
                        end
                    end

                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fm0_tx_encoder.sv
`timescale 1ns/1ps
`default_nettype none
module tb_fm0_tx_encoder;

    localparam int H    = 2;
    localparam int MAXC = 400;

    logic       clk        = 1'b0;
    logic       reset_n    = 1'b0;
    logic       en         = 1'b1;
    logic       start      = 1'b0;
    logic [7:0] byte_count = 8'd0;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_read;
    logic       tx_out;
    logic       busy;
    logic       done;
    logic       underrun;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Simple byte FIFO: output register updated on a pop.
    logic [7:0] fifo_mem [0:255];
    int         fifo_wr   = 0;
    int         fifo_rd   = 0;
    logic       flush_req = 1'b0;
    logic [7:0] fifo_q    = 8'd0;

    assign fifo_empty = (fifo_rd == fifo_wr);
    assign fifo_data  = fifo_q;

    always @(posedge clk) begin
        if (flush_req) begin
            fifo_rd <= fifo_wr;
        end else if (fifo_read && !fifo_empty) begin
            fifo_q  <= fifo_mem[fifo_rd[7:0]];
            fifo_rd <= fifo_rd + 1;
        end
    end

    fm0_tx_encoder #(.HALF_CYCLES(H)) dut (
        .i_clk        (clk),
        .i_reset_n    (reset_n),
        .i_en         (en),
        .i_start      (start),
        .i_byte_count (byte_count),
        .i_fifo_empty (fifo_empty),
        .i_fifo_data  (fifo_data),
        .o_fifo_read  (fifo_read),
        .o_tx_out     (tx_out),
        .o_busy       (busy),
        .o_done       (done),
        .o_underrun   (underrun)
    );

    // Observed and expected per-cycle traces (index = cycles after start edge)
    logic obs_tx [0:MAXC];
    logic obs_busy [0:MAXC];
    logic obs_done [0:MAXC];
    logic obs_rd [0:MAXC];
    logic obs_ur [0:MAXC];
    logic obs_empty [0:MAXC];
    logic exp_tx [0:MAXC];
    logic exp_busy [0:MAXC];
    logic exp_done [0:MAXC];
    logic exp_ur [0:MAXC];
    logic hs [0:299];
    logic [7:0] frame_bytes [0:15];
    int   exp_busy_cycles;
    int   exp_reads;

    task automatic push(input logic [7:0] b);
        fifo_mem[fifo_wr[7:0]] = b;
        fifo_wr = fifo_wr + 1;
    endtask

    task automatic flush_fifo;
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
    endtask

    // Reference: list of FM0 half-symbol levels, each stretched to H cycles.
    task automatic build_model(input int n, input int avail);
        logic [11:0] pv;
        logic        prev;
        logic        lvl;
        logic        b;
        int          nh;
        int          fail_half;
        bit          abort;
        pv = 12'b1101_0010_0011;
        nh = 0;
        for (int i = 11; i >= 0; i--) begin
            hs[nh] = pv[i];
            nh++;
        end
        prev = pv[0];
        for (int j = 0; j < n; j++) begin
            for (int i = 7; i >= 0; i--) begin
                b          = frame_bytes[j][i];
                lvl        = ~prev;
                hs[nh]     = lvl;
                hs[nh + 1] = b ? lvl : ~lvl;
                prev       = hs[nh + 1];
                nh         = nh + 2;
            end
        end
        lvl        = ~prev;
        hs[nh]     = lvl;
        hs[nh + 1] = lvl;
        nh         = nh + 2;
        abort      = (avail < n);
        fail_half  = (avail == 0) ? 0 : 12 + 16 * (avail - 1) + 14;
        exp_busy_cycles = abort ? (fail_half + 1) * H : nh * H;
        exp_reads  = abort ? avail : n;
        for (int k = 1; k < MAXC; k++) begin
            exp_busy[k] = (k <= exp_busy_cycles);
            exp_tx[k]   = exp_busy[k] ? hs[(k - 1) / H] : 1'b0;
            exp_done[k] = !abort && (k == exp_busy_cycles + 1);
            exp_ur[k]   = abort && (k > fail_half * H);
        end
    endtask

    // Pulses start and records ncyc cycles. Optional: en low for 7 edges
    // from stall_c, a stray start at ghost_c, reset at rst_c (0 = unused).
    task automatic drive_frame(input int bc, input int ncyc, input int stall_c,
                               input int ghost_c, input int rst_c);
        start      = 1'b1;
        byte_count = 8'(bc);
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            obs_tx[k]    = tx_out;
            obs_busy[k]  = busy;
            obs_done[k]  = done;
            obs_rd[k]    = fifo_read;
            obs_ur[k]    = underrun;
            obs_empty[k] = fifo_empty;
            start = 1'b0;
            if (ghost_c > 0 && k == ghost_c) begin
                start      = 1'b1;
                byte_count = 8'd7;
            end
            en      = !(stall_c > 0 && k >= stall_c && k < stall_c + 7);
            reset_n = !(rst_c > 0 && k == rst_c);
        end
        start   = 1'b0;
        en      = 1'b1;
        reset_n = 1'b1;
    endtask

    task automatic scan_reads(input int ncyc, output int reads, output int viol);
        reads = 0;
        viol  = 0;
        for (int k = 1; k <= ncyc; k++) begin
            if (obs_rd[k]) begin
                reads++;
                if (obs_empty[k]) viol++;
                if (k > 1 && obs_rd[k - 1]) viol++;
            end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (tx_out !== 1'b0)    begin n_fail++; $display("FAIL reset_tx got %b want 0", tx_out); end
        n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0)      begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_checks++; if (fifo_read !== 1'b0) begin n_fail++; $display("FAIL reset_rd got %b want 0", fifo_read); end
        n_checks++; if (underrun !== 1'b0)  begin n_fail++; $display("FAIL reset_ur got %b want 0", underrun); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_byte;
        logic [29:0] got_h;
        logic [29:0] want_h;
        int reads, viol, nbusy, ndone;
        frame_bytes[0] = 8'hA5;
        push(8'hA5);
        build_model(1, 1);
        drive_frame(1, 64, 0, 0, 0);
        for (int k = 1; k <= 64; k++) begin
            n_checks++;
            if ({obs_tx[k], obs_busy[k], obs_done[k], obs_ur[k]} !== {exp_tx[k], exp_busy[k], exp_done[k], exp_ur[k]}) begin
                n_fail++;
                $display("FAIL single_wave cyc %0d tx/busy/done/ur got %b%b%b%b want %b%b%b%b", k,
                         obs_tx[k], obs_busy[k], obs_done[k], obs_ur[k], exp_tx[k], exp_busy[k], exp_done[k], exp_ur[k]);
            end
        end
        want_h = 30'b110100100011_0010110101001011_00;
        nbusy = 0;
        ndone = 0;
        for (int i = 0; i < 30; i++) got_h[29 - i] = obs_tx[2 * i + 1];
        for (int k = 1; k <= 64; k++) begin
            if (obs_busy[k]) nbusy++;
            if (obs_done[k]) ndone++;
        end
        n_checks++; if (got_h !== want_h) begin n_fail++; $display("FAIL single_halves got %b want %b", got_h, want_h); end
        n_checks++; if (nbusy != 60) begin n_fail++; $display("FAIL single_busy_len got %0d want 60", nbusy); end
        n_checks++; if (ndone != 1)  begin n_fail++; $display("FAIL single_done_cnt got %0d want 1", ndone); end
        scan_reads(64, reads, viol);
        n_checks++; if (reads != 1) begin n_fail++; $display("FAIL single_reads got %0d want 1", reads); end
        n_checks++; if (viol != 0)  begin n_fail++; $display("FAIL single_rd_protocol got %0d want 0", viol); end
    endtask

    task automatic test_back_to_back;
        int reads, viol, bad00, badff;
        frame_bytes[0] = 8'h00;
        frame_bytes[1] = 8'hFF;
        push(8'h00);
        push(8'hFF);
        build_model(2, 2);
        drive_frame(2, 96, 0, 10, 0);
        for (int k = 1; k <= 96; k++) begin
            n_checks++;
            if ({obs_tx[k], obs_busy[k], obs_done[k], obs_ur[k]} !== {exp_tx[k], exp_busy[k], exp_done[k], exp_ur[k]}) begin
                n_fail++;
                $display("FAIL b2b_wave cyc %0d tx/busy/done/ur got %b%b%b%b want %b%b%b%b", k,
                         obs_tx[k], obs_busy[k], obs_done[k], obs_ur[k], exp_tx[k], exp_busy[k], exp_done[k], exp_ur[k]);
            end
        end
        bad00 = 0;
        badff = 0;
        for (int h = 12; h < 28; h++) if (obs_tx[2 * h + 1] === obs_tx[2 * h - 1]) bad00++;
        for (int h = 28; h < 44; h++) begin
            if (((h - 12) % 2) == 0) begin
                if (obs_tx[2 * h + 1] === obs_tx[2 * h - 1]) badff++;
            end else begin
                if (obs_tx[2 * h + 1] !== obs_tx[2 * h - 1]) badff++;
            end
        end
        n_checks++; if (bad00 != 0) begin n_fail++; $display("FAIL b2b_00_inversions got %0d bad halves want 0", bad00); end
        n_checks++; if (badff != 0) begin n_fail++; $display("FAIL b2b_ff_transitions got %0d bad halves want 0", badff); end
        scan_reads(96, reads, viol);
        n_checks++; if (reads != 2) begin n_fail++; $display("FAIL b2b_reads got %0d want 2", reads); end
        n_checks++; if (viol != 0)  begin n_fail++; $display("FAIL b2b_rd_protocol got %0d want 0", viol); end
    endtask

    task automatic test_underrun;
        int reads, viol;
        for (int j = 0; j < 3; j++) frame_bytes[j] = 8'($urandom);
        push(frame_bytes[0]);
        build_model(3, 1);
        drive_frame(3, 64, 0, 0, 0);
        for (int k = 1; k <= 64; k++) begin
            n_checks++;
            if ({obs_tx[k], obs_busy[k], obs_done[k], obs_ur[k]} !== {exp_tx[k], exp_busy[k], exp_done[k], exp_ur[k]}) begin
                n_fail++;
                $display("FAIL underrun_wave cyc %0d tx/busy/done/ur got %b%b%b%b want %b%b%b%b", k,
                         obs_tx[k], obs_busy[k], obs_done[k], obs_ur[k], exp_tx[k], exp_busy[k], exp_done[k], exp_ur[k]);
            end
        end
        scan_reads(64, reads, viol);
        n_checks++; if (reads != 1) begin n_fail++; $display("FAIL underrun_reads got %0d want 1", reads); end
        n_checks++; if (viol != 0)  begin n_fail++; $display("FAIL underrun_rd_protocol got %0d want 0", viol); end
    endtask

    task automatic test_enable_stall;
        int reads, viol, src;
        localparam int SC = 31;
        for (int j = 0; j < 2; j++) begin
            frame_bytes[j] = 8'($urandom);
            push(frame_bytes[j]);
        end
        build_model(2, 2);
        drive_frame(2, 103, SC, 0, 0);
        for (int k = 1; k <= 103; k++) begin
            src = (k <= SC) ? k : ((k <= SC + 7) ? SC : k - 7);
            n_checks++;
            if ({obs_tx[k], obs_busy[k], obs_done[k], obs_ur[k]} !== {exp_tx[src], exp_busy[src], exp_done[src], exp_ur[src]}) begin
                n_fail++;
                $display("FAIL stall_wave cyc %0d tx/busy/done/ur got %b%b%b%b want %b%b%b%b", k,
                         obs_tx[k], obs_busy[k], obs_done[k], obs_ur[k], exp_tx[src], exp_busy[src], exp_done[src], exp_ur[src]);
            end
        end
        scan_reads(103, reads, viol);
        n_checks++; if (reads != 2) begin n_fail++; $display("FAIL stall_reads got %0d want 2", reads); end
        n_checks++; if (viol != 0)  begin n_fail++; $display("FAIL stall_rd_protocol got %0d want 0", viol); end
    endtask

    task automatic test_zero_length;
        int active, ndone, reads, viol;
        drive_frame(0, 4, 0, 0, 0);
        active = 0;
        ndone  = 0;
        for (int k = 1; k <= 4; k++) begin
            if (obs_tx[k] !== 1'b0 || obs_busy[k] !== 1'b0) active++;
            if (obs_done[k]) ndone++;
        end
        n_checks++; if (obs_done[1] !== 1'b1) begin n_fail++; $display("FAIL zero_done_cyc1 got %b want 1", obs_done[1]); end
        n_checks++; if (ndone != 1)  begin n_fail++; $display("FAIL zero_done_cnt got %0d want 1", ndone); end
        n_checks++; if (active != 0) begin n_fail++; $display("FAIL zero_tx_busy got %0d active cycles want 0", active); end
        scan_reads(4, reads, viol);
        n_checks++; if (reads != 0) begin n_fail++; $display("FAIL zero_reads got %0d want 0", reads); end
    endtask

    task automatic test_reset_mid_frame;
        int reads, viol;
        for (int j = 0; j < 3; j++) push(8'($urandom));
        drive_frame(3, 42, 0, 0, 40);
        n_checks++; if (obs_tx[41] !== 1'b0)   begin n_fail++; $display("FAIL midrst_tx got %b want 0", obs_tx[41]); end
        n_checks++; if (obs_busy[41] !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", obs_busy[41]); end
        n_checks++; if (obs_rd[41] !== 1'b0)   begin n_fail++; $display("FAIL midrst_rd got %b want 0", obs_rd[41]); end
        n_checks++; if (obs_ur[41] !== 1'b0)   begin n_fail++; $display("FAIL midrst_ur got %b want 0", obs_ur[41]); end
        flush_fifo();
        for (int j = 0; j < 2; j++) begin
            frame_bytes[j] = 8'($urandom);
            push(frame_bytes[j]);
        end
        build_model(2, 2);
        drive_frame(2, 96, 0, 0, 0);
        for (int k = 1; k <= 96; k++) begin
            n_checks++;
            if ({obs_tx[k], obs_busy[k], obs_done[k], obs_ur[k]} !== {exp_tx[k], exp_busy[k], exp_done[k], exp_ur[k]}) begin
                n_fail++;
                $display("FAIL postrst_wave cyc %0d tx/busy/done/ur got %b%b%b%b want %b%b%b%b", k,
                         obs_tx[k], obs_busy[k], obs_done[k], obs_ur[k], exp_tx[k], exp_busy[k], exp_done[k], exp_ur[k]);
            end
        end
        scan_reads(96, reads, viol);
        n_checks++; if (reads != 2) begin n_fail++; $display("FAIL postrst_reads got %0d want 2", reads); end
    endtask

    task automatic test_random_frames;
        int n, len, reads, viol;
        for (int f = 0; f < 3; f++) begin
            n = $urandom_range(1, 4);
            for (int j = 0; j < n; j++) begin
                frame_bytes[j] = 8'($urandom);
                push(frame_bytes[j]);
            end
            build_model(n, n);
            len = exp_busy_cycles + 3;
            drive_frame(n, len, 0, 0, 0);
            for (int k = 1; k <= len; k++) begin
                n_checks++;
                if ({obs_tx[k], obs_busy[k], obs_done[k], obs_ur[k]} !== {exp_tx[k], exp_busy[k], exp_done[k], exp_ur[k]}) begin
                    n_fail++;
                    $display("FAIL rand%0d_wave cyc %0d tx/busy/done/ur got %b%b%b%b want %b%b%b%b", f, k,
                             obs_tx[k], obs_busy[k], obs_done[k], obs_ur[k], exp_tx[k], exp_busy[k], exp_done[k], exp_ur[k]);
                end
            end
            scan_reads(len, reads, viol);
            n_checks++; if (reads != exp_reads) begin n_fail++; $display("FAIL rand%0d_reads got %0d want %0d", f, reads, exp_reads); end
            n_checks++; if (viol != 0) begin n_fail++; $display("FAIL rand%0d_rd_protocol got %0d want 0", f, viol); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_underrun();
        test_enable_stall();
        test_zero_length();
        test_reset_mid_frame();
        test_random_frames();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
